// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS control FSM: sequences IF/ID/EX/MEM/WB and drives datapath strobes.
// Outputs are combinational from state/op_q/fn_q; only branch-EX pc_we also follows zero.
module mips_mc_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  opcode,
  input  logic [5:0]  func,
  input  logic        zero,
  output logic        pc_we,
  output logic [1:0]  pc_src,
  output logic        ir_we,
  output logic        rf_we,
  output logic        reg_dst,
  output logic [1:0]  alu_src_b,
  output logic [3:0]  alu_op,
  output logic        mem_we,
  output logic        mem_to_reg,
  output logic [2:0]  state,
  output logic        illegal,
  output logic [31:0] inst_cnt
);
  localparam logic [2:0] S_IF = 3'd0, S_ID = 3'd1, S_EX = 3'd2, S_MEM = 3'd3,
                         S_WB = 3'd4, S_RST = 3'd7;

  localparam logic [5:0] OP_R = 6'h00, OP_ADDI = 6'h08, OP_SLTI = 6'h0A, OP_ANDI = 6'h0C,
                         OP_ORI = 6'h0D, OP_XORI = 6'h0E, OP_LW = 6'h23, OP_SW = 6'h2B,
                         OP_BEQ = 6'h04, OP_BNE = 6'h05, OP_J = 6'h02;

  logic [2:0]  next_state;
  logic [5:0]  op_q, fn_q;
  logic        legal_in;
  logic        retire;
  logic        is_branch;

  always_comb begin
    legal_in = 1'b0;
    case (opcode)
      OP_R: case (func)
        6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h00, 6'h02: legal_in = 1'b1;
        default: legal_in = 1'b0;
      endcase
      OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI,
      OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J: legal_in = 1'b1;
      default: legal_in = 1'b0;
    endcase
  end

  assign is_branch = (op_q == OP_BEQ) || (op_q == OP_BNE) || (op_q == OP_J);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_RST;
    else      state <= next_state;
  end

  always_comb begin
    next_state = S_IF;
    case (state)
      S_RST: next_state = S_IF;
      S_IF:  next_state = S_ID;
      S_ID:  next_state = legal_in ? S_EX : S_IF;
      S_EX: begin
        if (op_q == OP_LW || op_q == OP_SW) next_state = S_MEM;
        else if (is_branch)                 next_state = S_IF;
        else                                next_state = S_WB;
      end
      S_MEM: next_state = (op_q == OP_SW) ? S_IF : S_WB;
      S_WB:  next_state = S_IF;
      default: next_state = S_IF;
    endcase
  end

  always_comb begin
    pc_we      = 1'b0;
    pc_src     = 2'b00;
    ir_we      = 1'b0;
    rf_we      = 1'b0;
    reg_dst    = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 4'd0;
    mem_we     = 1'b0;
    mem_to_reg = 1'b0;
    retire     = 1'b0;
    case (state)
      S_IF: begin
        ir_we = 1'b1;
        pc_we = 1'b1;
      end
      S_EX, S_MEM, S_WB: begin
        // Decoded controls stay stable across every post-ID state of the instruction.
        reg_dst    = (op_q == OP_R);
        mem_to_reg = (op_q == OP_LW);
        case (op_q)
          OP_R: case (fn_q)
            6'h22:   alu_op = 4'd1;
            6'h24:   alu_op = 4'd2;
            6'h25:   alu_op = 4'd3;
            6'h26:   alu_op = 4'd4;
            6'h27:   alu_op = 4'd5;
            6'h2A:   alu_op = 4'd6;
            6'h00:   alu_op = 4'd7;
            6'h02:   alu_op = 4'd8;
            default: alu_op = 4'd0;
          endcase
          OP_ADDI:      begin alu_op = 4'd0; alu_src_b = 2'b01; end
          OP_SLTI:      begin alu_op = 4'd6; alu_src_b = 2'b01; end
          OP_ANDI:      begin alu_op = 4'd2; alu_src_b = 2'b10; end
          OP_ORI:       begin alu_op = 4'd3; alu_src_b = 2'b10; end
          OP_XORI:      begin alu_op = 4'd4; alu_src_b = 2'b10; end
          OP_LW, OP_SW: begin alu_op = 4'd0; alu_src_b = 2'b01; end
          OP_BEQ, OP_BNE: alu_op = 4'd1;
          default: ;
        endcase
        if (state == S_EX) begin
          case (op_q)
            OP_BEQ: begin pc_src = 2'b01; pc_we = zero;  end
            OP_BNE: begin pc_src = 2'b01; pc_we = !zero; end
            OP_J:   begin pc_src = 2'b10; pc_we = 1'b1;  end
            default: ;
          endcase
          retire = is_branch;
        end else if (state == S_MEM) begin
          mem_we = (op_q == OP_SW);
          retire = (op_q == OP_SW);
        end else begin
          rf_we  = 1'b1;
          retire = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q     <= 6'd0;
      fn_q     <= 6'd0;
      illegal  <= 1'b0;
      inst_cnt <= 32'd0;
    end else begin
      if (state == S_ID) begin
        op_q <= opcode;
        fn_q <= func;
        if (!legal_in) illegal <= 1'b1;
      end
      if (retire) inst_cnt <= inst_cnt + 32'd1;
    end
  end
endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Directed bench for mips_mc_ctrl: walks each instruction class cycle by cycle.
module tb_mips_mc_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  opcode, func;
  logic        zero;
  logic        pc_we, ir_we, rf_we, reg_dst, mem_we, mem_to_reg, illegal;
  logic [1:0]  pc_src, alu_src_b;
  logic [3:0]  alu_op;
  logic [2:0]  state;
  logic [31:0] inst_cnt;

  int pass_cnt = 0;
  int total_cnt = 0;

  mips_mc_ctrl dut (
    .clk(clk), .rst(rst), .opcode(opcode), .func(func), .zero(zero),
    .pc_we(pc_we), .pc_src(pc_src), .ir_we(ir_we), .rf_we(rf_we),
    .reg_dst(reg_dst), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .mem_we(mem_we), .mem_to_reg(mem_to_reg), .state(state),
    .illegal(illegal), .inst_cnt(inst_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_strobes_off(input string tag);
    check({tag, ".strobes"}, {28'd0, pc_we, ir_we, rf_we, mem_we}, 32'd0);
  endtask

  initial begin
    rst = 1'b0; opcode = 6'h00; func = 6'h20; zero = 1'b0;
    #12;
    check("rst.state", state, 7);
    check_strobes_off("rst");
    check("rst.cnt", inst_cnt, 0);
    check("rst.illegal", illegal, 0);
    rst = 1'b1;
    tick();
    check("if0.state", state, 0);
    check("if0.ir_pc", {ir_we, pc_we, pc_src}, 4'b1100);

    // add: IF ID EX WB
    tick(); check("add.id", state, 1);
    tick(); check("add.ex", state, 2);
    check("add.ex.alu", {alu_op, alu_src_b}, 6'b000000);
    check_strobes_off("add.ex");
    tick(); check("add.wb", state, 4);
    check("add.wb.ctl", {rf_we, reg_dst, mem_to_reg, mem_we, alu_op}, 8'b1100_0000);
    check("add.wb.cnt", inst_cnt, 0);
    tick(); check("add.done", state, 0);
    check("add.cnt", inst_cnt, 1);

    // second add, reset asserted during EX
    tick(); tick(); check("add2.ex", state, 2);
    rst = 1'b0; #1;
    check("mid.rst.state", state, 7);
    check_strobes_off("mid.rst");
    check("mid.rst.cnt", inst_cnt, 0);
    check("mid.rst.ctl", {reg_dst, alu_src_b, alu_op, mem_to_reg}, 0);
    #2 rst = 1'b1;
    tick(); check("rel.state", state, 0);
    check("rel.ir_pc", {ir_we, pc_we}, 2'b11);

    // lw
    opcode = 6'h23; func = 6'h00;
    tick(); check("lw.id", state, 1);
    tick(); check("lw.ex", state, 2);
    check("lw.ex.alu", {alu_op, alu_src_b}, {4'd0, 2'b01});
    tick(); check("lw.mem", state, 3);
    check_strobes_off("lw.mem");
    tick(); check("lw.wb", state, 4);
    check("lw.wb.ctl", {rf_we, mem_to_reg, reg_dst, alu_src_b, mem_we}, 6'b110010);
    tick(); check("lw.done", state, 0);

    // sw
    opcode = 6'h2B;
    tick(); tick(); check("sw.ex", state, 2);
    tick(); check("sw.mem", state, 3);
    check("sw.mem.we", {mem_we, rf_we}, 2'b10);
    tick(); check("sw.done", state, 0);
    check("lwsw.cnt", inst_cnt, 2);

    // beq
    opcode = 6'h04; zero = 1'b1;
    tick(); tick(); check("beq.ex", state, 2);
    check("beq.z1", {pc_we, pc_src, alu_op, alu_src_b}, {1'b1, 2'b01, 4'd1, 2'b00});
    zero = 1'b0; #1;
    check("beq.z0", pc_we, 0);
    tick(); check("beq.done", state, 0);
    check("beq.cnt", inst_cnt, 3);

    // bne
    opcode = 6'h05; zero = 1'b0;
    tick(); tick();
    check("bne.z0", {pc_we, pc_src}, 3'b101);
    zero = 1'b1; #1;
    check("bne.z1", pc_we, 0);
    tick(); check("bne.done", state, 0);
    check("bne.cnt", inst_cnt, 4);
    zero = 1'b0;

    // illegal opcode
    opcode = 6'h3F;
    tick(); check("ill.id", state, 1);
    check_strobes_off("ill.id");
    tick(); check("ill.back", state, 0);
    check("ill.flag", illegal, 1);
    check("ill.cnt", inst_cnt, 4);

    // ori
    opcode = 6'h0D;
    tick(); tick(); check("ori.ex", state, 2);
    check("ori.ex.alu", {alu_op, alu_src_b}, {4'd3, 2'b10});
    tick(); check("ori.wb", state, 4);
    check("ori.wb.ctl", {rf_we, reg_dst, mem_to_reg}, 3'b100);
    tick(); check("ori.done", state, 0);
    check("ori.cnt", inst_cnt, 5);
    check("ori.sticky", illegal, 1);

    // j
    opcode = 6'h02;
    tick(); tick(); check("j.ex", state, 2);
    check("j.ex.pc", {pc_we, pc_src}, 3'b110);
    tick(); check("j.done", state, 0);
    check("j.cnt", inst_cnt, 6);

    // srl and slti decode
    opcode = 6'h00; func = 6'h02;
    tick(); tick();
    check("srl.alu", {alu_op, alu_src_b}, {4'd8, 2'b00});
    tick(); tick();
    opcode = 6'h0A;
    tick(); tick();
    check("slti.alu", {alu_op, alu_src_b}, {4'd6, 2'b01});
    tick(); tick();
    check("slti.cnt", inst_cnt, 8);

    // R-type with bad func
    opcode = 6'h00; func = 6'h3F;
    tick(); check("rbad.id", state, 1);
    tick(); check("rbad.back", state, 0);
    check("rbad.cnt", inst_cnt, 8);

    rst = 1'b0; #1;
    check("final.illegal", illegal, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/mips_mc_ctrl.md
# mips_mc_ctrl

Multi-cycle control unit for the MIPS datapath. It sits directly downstream of the instruction fetch/decode stage and consumes that stage's decoded `opcode`/`func` fields. It sequences each instruction through IF/ID/EX/MEM/WB and drives the PC, IR, register-file, ALU and data-memory strobes. It also keeps a retired-instruction counter and a sticky illegal-instruction flag.

## Interface

- No parameters.

- `clk`  in  1  system clock, rising-edge
- `rst`  in  1  asynchronous, active-low reset
- `opcode`  in  6  instruction[31:26] from fetch/decode
- `func`  in  6  instruction[5:0] from fetch/decode
- `zero`  in  1  ALU zero flag, valid in EX
- `pc_we`  out  1  PC register load enable
- `pc_src`  out  2  00 = PC+4, 01 = branch target, 10 = jump target
- `ir_we`  out  1  instruction register load enable
- `rf_we`  out  1  register-file write enable
- `reg_dst`  out  1  1 = rd, 0 = rt
- `alu_src_b`  out  2  00 = rt data, 01 = sign-ext imm, 10 = zero-ext imm
- `alu_op`  out  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLT, 7 SLL, 8 SRL
- `mem_we`  out  1  data-memory write enable
- `mem_to_reg`  out  1  1 = write-back data comes from memory
- `state`  out  3  current FSM state
- `illegal`  out  1  sticky, set on an undecodable instruction
- `inst_cnt`  out  32  retired legal-instruction count

## Operation

- States: RST=7, IF=0, ID=1, EX=2, MEM=3, WB=4.
- Supported opcodes:
  - R-type 0x00, with func 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x26 xor, 0x27 nor, 0x2A slt, 0x00 sll, 0x02 srl
  - addi 0x08, slti 0x0A, andi 0x0C, ori 0x0D, xori 0x0E
  - lw 0x23, sw 0x2B, beq 0x04, bne 0x05, j 0x02
  - Any other opcode, or an R-type with any other func, is illegal.
- RST: all strobes are 0. Next state is IF.
- IF: `ir_we`=1, `pc_we`=1, `pc_src`=00. Next state is ID.
- ID: `opcode`/`func` are latched into internal op_q/fn_q at the closing edge.
  - Legal instruction: next state is EX.
  - Illegal instruction: `illegal` is set and the next state is IF. No write of any kind occurs.
- EX: `alu_op`/`alu_src_b` are decoded from op_q/fn_q.
  - R-type or I-ALU: next state is WB.
  - lw/sw: `alu_op`=ADD, `alu_src_b`=01, next state is MEM.
  - beq: `alu_op`=SUB, `alu_src_b`=00, `pc_src`=01, `pc_we`=`zero`.
  - bne: same as beq but `pc_we`=!`zero`. Branches then go to IF.
  - j: `pc_we`=1, `pc_src`=10, next state is IF.
- MEM:
  - sw: `mem_we`=1, next state is IF.
  - lw: no strobes, next state is WB.
- WB: `rf_we`=1.
  - `reg_dst`=1 for R-type, otherwise 0.
  - `mem_to_reg`=1 for lw only.
  - Next state is IF.
- `alu_src_b` selection: andi/ori/xori use 10. addi/slti/lw/sw use 01. R-type and branches use 00.
- `alu_op`, `alu_src_b`, `reg_dst` and `mem_to_reg` hold their decoded value from EX through WB. They are 0 in RST, IF and ID.
- `inst_cnt` increments by 1 on the closing edge of the last state of each legal instruction (WB, sw-MEM, branch/j EX). It wraps from 0xFFFFFFFF to 0. Illegal instructions do not count.
- `illegal` is cleared only by reset.

## Timing

- Asserting `rst` (low) asynchronously forces: state=RST, op_q/fn_q=0, `illegal`=0, `inst_cnt`=0, all strobes 0. This applies in any state, including mid-instruction.
- After `rst` is released, the first rising edge moves RST→IF.
- Outputs are combinational from state, op_q and fn_q. The only exception is `pc_we` in a branch EX, which also depends on `zero` in the same cycle.
- Latency per instruction:
  - R/I-ALU: 4 cycles
  - lw: 5 cycles
  - sw: 4 cycles
  - beq/bne/j: 3 cycles
  - illegal: 2 cycles
- The fetch stage loads the IR on the IF closing edge, so `opcode`/`func` must be stable throughout ID. They are ignored in every other state.
- `pc_we` asserts at most once outside IF per instruction (branch/j EX only).
- Strobes are single-cycle. `rf_we` and `mem_we` are never high in the same cycle.

## Test plan

- Reset: pull `rst` low during EX of an add → state=7 immediately, all strobes 0, `inst_cnt`=0. Release, then one edge → state=0 with `ir_we`=`pc_we`=1.
- add (opcode 0x00, func 0x20) → states 0,1,2,4. In WB: `rf_we`=1, `reg_dst`=1, `alu_op`=0, `mem_to_reg`=0. `inst_cnt` goes 0→1 after 4 cycles.
- lw (0x23) then sw (0x2B):
  - lw → states 0,1,2,3,4; WB has `rf_we`=1, `mem_to_reg`=1, `reg_dst`=0, `alu_src_b`=01.
  - sw → states 0,1,2,3; MEM has `mem_we`=1 and `rf_we` stays 0.
  - `inst_cnt`=2.
- Branches:
  - beq (0x04) with `zero`=1 → EX `pc_we`=1, `pc_src`=01. With `zero`=0 → `pc_we`=0.
  - bne (0x05) is the inverse.
  - Each takes 3 cycles and counts 1.
- Illegal opcode 0x3F → states 0,1,0. `illegal`=1 and stays 1; no `rf_we`/`mem_we`; `inst_cnt` unchanged. A following ori (0x0D) completes in 4 cycles with `alu_src_b`=10, `alu_op`=3.
- j (0x02) → EX `pc_we`=1, `pc_src`=10, then back to IF. R-type func 0x3F is flagged illegal.
